// File: rtl/sdram_rw_sched.sv
// sdram_rw_sched: arbitrates the AXI-side write/read FIFOs onto a 16-bit sdram_controller.
// Each 32-bit word becomes two halfword accesses, and each access is guarded by a watchdog.
module sdram_rw_sched #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SD_DW       = 16,
  parameter int HADDR_WIDTH = 24,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                   SD_clk,
  input  logic                   ARESETn,
  input  logic                   WADDR_FIFO_EMPTY,
  input  logic                   WDATA_FIFO_EMPTY,
  input  logic [ADDR_WIDTH-1:0]  SD_WR_ADDR_OUT,
  input  logic [DATA_WIDTH-1:0]  SD_WR_DATA_OUT,
  output logic                   SD_WR_ADDR_EN,
  output logic                   SD_WR_DATA_EN,
  input  logic                   RADDR_FIFO_EMPTY,
  input  logic [ADDR_WIDTH-1:0]  SD_RD_ADDR_OUT,
  output logic                   SD_RD_ADDR_EN,
  input  logic                   RDATA_FIFO_FULL,
  output logic [DATA_WIDTH-1:0]  SD_RD_DATA_IN,
  output logic                   SD_RD_DATA_EN,
  output logic [HADDR_WIDTH-1:0] wr_addr,
  output logic [SD_DW-1:0]       wr_data,
  output logic                   wr_enable,
  output logic [HADDR_WIDTH-1:0] rd_addr,
  output logic                   rd_enable,
  input  logic [SD_DW-1:0]       rd_data,
  input  logic                   rd_ready,
  input  logic                   busy,
  output logic                   wdog_err
);

  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, POP, LATCH, ISSUE, ACK, DONE, FIN} state_t;

  state_t                  state;
  logic                    is_read;
  logic                    last_read;
  logic                    beat;
  logic                    seen_busy;
  logic [HADDR_WIDTH-2:0]  word_addr;
  logic [SD_DW-1:0]        wdata_hi;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [WDOG_W-1:0]       wdog_cnt;
  logic                    wr_pend;
  logic                    rd_pend;
  logic                    grant_read;
  logic                    wdog_expired;
  logic                    ack_done;
  logic                    unused_addr_bits;

  assign wr_pend      = !WADDR_FIFO_EMPTY && !WDATA_FIFO_EMPTY;
  assign rd_pend      = !RADDR_FIFO_EMPTY && !RDATA_FIFO_FULL;
  // On a tie the grant goes to whichever side was not served last.
  assign grant_read   = rd_pend && (!wr_pend || !last_read);
  assign wdog_expired = (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
  assign ack_done     = is_read ? rd_ready : (seen_busy && !busy);

  assign unused_addr_bits = ^{SD_WR_ADDR_OUT[ADDR_WIDTH-1:HADDR_WIDTH+1], SD_WR_ADDR_OUT[1:0],
                              SD_RD_ADDR_OUT[ADDR_WIDTH-1:HADDR_WIDTH+1], SD_RD_ADDR_OUT[1:0]};

  always_ff @(posedge SD_clk or negedge ARESETn) begin
    if (!ARESETn) begin
      state         <= IDLE;
      is_read       <= 1'b0;
      last_read     <= 1'b1;
      beat          <= 1'b0;
      seen_busy     <= 1'b0;
      word_addr     <= '0;
      wdata_hi      <= '0;
      rdata         <= '0;
      wdog_cnt      <= '0;
      SD_WR_ADDR_EN <= 1'b0;
      SD_WR_DATA_EN <= 1'b0;
      SD_RD_ADDR_EN <= 1'b0;
      SD_RD_DATA_IN <= '0;
      SD_RD_DATA_EN <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_enable     <= 1'b0;
      rd_addr       <= '0;
      rd_enable     <= 1'b0;
      wdog_err      <= 1'b0;
    end else begin
      SD_WR_ADDR_EN <= 1'b0;
      SD_WR_DATA_EN <= 1'b0;
      SD_RD_ADDR_EN <= 1'b0;
      SD_RD_DATA_EN <= 1'b0;
      wr_enable     <= 1'b0;
      rd_enable     <= 1'b0;

      case (state)
        IDLE: begin
          if (wr_pend || rd_pend) begin
            is_read   <= grant_read;
            last_read <= grant_read;
            if (grant_read) begin
              SD_RD_ADDR_EN <= 1'b1;
            end else begin
              SD_WR_ADDR_EN <= 1'b1;
              SD_WR_DATA_EN <= 1'b1;
            end
            state <= POP;
          end
        end

        POP: state <= LATCH;

        // FIFO heads are valid the cycle after the pop.
        LATCH: begin
          beat     <= 1'b0;
          wdog_cnt <= '0;
          if (is_read) begin
            word_addr <= SD_RD_ADDR_OUT[HADDR_WIDTH:2];
            rd_addr   <= {SD_RD_ADDR_OUT[HADDR_WIDTH:2], 1'b0};
          end else begin
            word_addr <= SD_WR_ADDR_OUT[HADDR_WIDTH:2];
            wdata_hi  <= SD_WR_DATA_OUT[DATA_WIDTH-1:SD_DW];
            wr_addr   <= {SD_WR_ADDR_OUT[HADDR_WIDTH:2], 1'b0};
            wr_data   <= SD_WR_DATA_OUT[SD_DW-1:0];
          end
          state <= ISSUE;
        end

        ISSUE: begin
          if (!busy) begin
            if (is_read) rd_enable <= 1'b1;
            else         wr_enable <= 1'b1;
            seen_busy <= 1'b0;
            wdog_cnt  <= wdog_cnt + WDOG_W'(1);
            state     <= ACK;
          end else if (wdog_expired) begin
            wdog_err <= 1'b1;
            state    <= IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
          end
        end

        // Writes complete on a busy rise then fall; reads on the rd_ready strobe.
        ACK: begin
          if (ack_done) begin
            if (is_read) begin
              if (beat) rdata[DATA_WIDTH-1:SD_DW] <= rd_data;
              else      rdata[SD_DW-1:0]          <= rd_data;
            end
            state <= DONE;
          end else if (wdog_expired) begin
            wdog_err <= 1'b1;
            state    <= IDLE;
          end else begin
            seen_busy <= seen_busy | busy;
            wdog_cnt  <= wdog_cnt + WDOG_W'(1);
          end
        end

        DONE: begin
          if (!beat) begin
            beat     <= 1'b1;
            wdog_cnt <= '0;
            if (is_read) begin
              rd_addr <= {word_addr, 1'b1};
            end else begin
              wr_addr <= {word_addr, 1'b1};
              wr_data <= wdata_hi;
            end
            state <= ISSUE;
          end else begin
            if (is_read) begin
              SD_RD_DATA_IN <= rdata;
              SD_RD_DATA_EN <= 1'b1;
            end
            state <= FIN;
          end
        end

        FIN: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
